// File: rtl/if_stage_pkg.sv
// Shared definitions for the IF pipeline stage: default bus widths, the
// stale-response counter limits and the counter next-value helper.
package if_stage_pkg;

    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned EXC_W_DEF  = 16;

    // The stale-response counter is two bits wide; 3 means the counter is full.
    localparam int unsigned            DISCARD_W   = 2;
    localparam logic [DISCARD_W-1:0]   DISCARD_MAX = 2'd3;

    // Unclamped next value of the stale-response counter. A decrement is
    // ignored when the counter is already empty. One extra bit is kept so
    // that overflow stays visible to the caller.
    function automatic logic [DISCARD_W:0] discard_sum(
        input logic [DISCARD_W-1:0] cnt,
        input logic                 inc0,
        input logic                 inc1,
        input logic                 dec
    );
        logic dec_eff;
        dec_eff = dec && (cnt != '0);
        return {1'b0, cnt} + {{DISCARD_W{1'b0}}, inc0} + {{DISCARD_W{1'b0}}, inc1}
               - {{DISCARD_W{1'b0}}, dec_eff};
    endfunction

endpackage

// File: rtl/if_stage_discard_cnt.sv
// Stale-response counter. It counts the instruction SRAM responses that still
// belong to killed fetches, so that those responses can be dropped later.
// It takes up to two increments per cycle (the current IF entry and the PreIF
// entry) and one decrement (a dropped response). It saturates at 3.
module if_discard_cnt
    import if_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc0_i,
    input  logic inc1_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [DISCARD_W-1:0] cnt_q;
    logic [DISCARD_W-1:0] cnt_d;
    logic [DISCARD_W:0]   sum;

    // Net update of the counter, clamped at the limit
    always_comb begin
        sum   = discard_sum(cnt_q, inc0_i, inc1_i, dec_i);
        cnt_d = (sum > {1'b0, DISCARD_MAX}) ? DISCARD_MAX : sum[DISCARD_W-1:0];
    end

    // Counter register
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. Every flop then
        // samples values from before the edge, whatever order the blocks run in.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

    // If the counter reaches its limit, killed responses are being tracked
    // deeper than the memory interface can have outstanding.
    assert property (@(posedge clk) disable iff (rst) (sum < {1'b0, DISCARD_MAX}));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch pipeline stage, placed between PreIF and ID. It takes one
// fetch entry per handshake and waits for the instruction SRAM response. It
// buffers the instruction while ID stalls, and it drops responses that belong
// to fetches killed by a flush. It also sends the sequential-PC hint back to
// PreIF.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned EXC_W  = EXC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              preif_valid_i,
    input  logic              preif_req_i,
    input  logic [PC_W-1:0]   preif_pc_i,
    input  logic              preif_excep_en_i,
    input  logic [EXC_W-1:0]  preif_excep_type_i,
    output logic              now_allowin_o,
    input  logic              flush_i,
    input  logic              inst_sram_data_ok_i,
    input  logic [INST_W-1:0] inst_sram_rdata_i,
    input  logic              next_allowin_i,
    output logic              now_to_next_valid_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_excep_en_o,
    output logic [EXC_W-1:0]  id_excep_type_o,
    output logic              order_we_o,
    output logic [PC_W-1:0]   order_pc_o
);

    logic              valid_q,    valid_d;
    logic              req_q,      req_d;
    logic [PC_W-1:0]   pc_q,       pc_d;
    logic              exc_en_q,   exc_en_d;
    logic [EXC_W-1:0]  exc_type_q, exc_type_d;
    logic [INST_W-1:0] ibuf_q,     ibuf_d;
    logic              ibuf_vld_q, ibuf_vld_d;
    logic              order_q,    order_d;

    logic discard_zero;
    logic data_hit;
    logic drop;
    logic ready_go;
    logic accept;
    logic leave;
    logic capture;
    logic kill_cur;
    logic kill_pre;

    // Handshake, response classification and flush bookkeeping
    always_comb begin
        data_hit            = inst_sram_data_ok_i && discard_zero;
        drop                = inst_sram_data_ok_i && !discard_zero;
        ready_go            = valid_q && (!req_q || exc_en_q || ibuf_vld_q || data_hit);
        now_allowin_o       = !valid_q || (ready_go && next_allowin_i);
        now_to_next_valid_o = valid_q && ready_go && !flush_i;
        accept              = preif_valid_i && now_allowin_o && !flush_i;
        leave               = now_to_next_valid_o && next_allowin_i;
        // The response arrived but ID did not take it, so keep it until ID does.
        capture             = valid_q && req_q && !ibuf_vld_q && data_hit && !leave;
        // A flushed fetch whose response is still outstanding must be dropped later.
        kill_cur            = flush_i && valid_q && req_q && !ibuf_vld_q && !data_hit;
        kill_pre            = flush_i && preif_valid_i && preif_req_i;
    end

    // Next state of the stage registers: flush, then accept, then handoff, then capture
    always_comb begin
        // NOTE: each next-state signal starts from its current value. Then
        // every path through the block assigns it, and no latch is inferred.
        valid_d    = valid_q;
        req_d      = req_q;
        pc_d       = pc_q;
        exc_en_d   = exc_en_q;
        exc_type_d = exc_type_q;
        ibuf_d     = ibuf_q;
        ibuf_vld_d = ibuf_vld_q;
        order_d    = order_q;
        if (flush_i) begin
            valid_d    = 1'b0;
            ibuf_vld_d = 1'b0;
            order_d    = 1'b0;
        end else if (accept) begin
            valid_d    = 1'b1;
            req_d      = preif_req_i;
            pc_d       = preif_pc_i;
            exc_en_d   = preif_excep_en_i;
            exc_type_d = preif_excep_type_i;
            ibuf_vld_d = 1'b0;
            order_d    = preif_req_i;
        end else if (leave) begin
            valid_d    = 1'b0;
            ibuf_vld_d = 1'b0;
            order_d    = 1'b0;
        end else if (capture) begin
            ibuf_d     = inst_sram_rdata_i;
            ibuf_vld_d = 1'b1;
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            pc_q       <= '0;
            exc_en_q   <= 1'b0;
            exc_type_q <= '0;
            ibuf_q     <= '0;
            ibuf_vld_q <= 1'b0;
            order_q    <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            req_q      <= req_d;
            pc_q       <= pc_d;
            exc_en_q   <= exc_en_d;
            exc_type_q <= exc_type_d;
            ibuf_q     <= ibuf_d;
            ibuf_vld_q <= ibuf_vld_d;
            order_q    <= order_d;
        end
    end

    if_discard_cnt u_discard_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc0_i (kill_cur),
        .inc1_i (kill_pre),
        .dec_i  (drop),
        .zero_o (discard_zero)
    );

    // Outputs to ID and the sequential-PC hint to PreIF
    always_comb begin
        id_pc_o         = pc_q;
        id_excep_en_o   = exc_en_q;
        id_excep_type_o = exc_type_q;
        id_inst_o       = ibuf_vld_q ? ibuf_q : (req_q ? inst_sram_rdata_i : '0);
        order_we_o      = order_q && valid_q;
        order_pc_o      = pc_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. Inputs change 1 ns after each rising edge.
// Outputs are sampled 2 ns after the edge, well away from the next one.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        preif_valid_i;
    logic        preif_req_i;
    logic [31:0] preif_pc_i;
    logic        preif_excep_en_i;
    logic [15:0] preif_excep_type_i;
    logic        now_allowin_o;
    logic        flush_i;
    logic        inst_sram_data_ok_i;
    logic [31:0] inst_sram_rdata_i;
    logic        next_allowin_i;
    logic        now_to_next_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_excep_en_o;
    logic [15:0] id_excep_type_o;
    logic        order_we_o;
    logic [31:0] order_pc_o;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .preif_valid_i       (preif_valid_i),
        .preif_req_i         (preif_req_i),
        .preif_pc_i          (preif_pc_i),
        .preif_excep_en_i    (preif_excep_en_i),
        .preif_excep_type_i  (preif_excep_type_i),
        .now_allowin_o       (now_allowin_o),
        .flush_i             (flush_i),
        .inst_sram_data_ok_i (inst_sram_data_ok_i),
        .inst_sram_rdata_i   (inst_sram_rdata_i),
        .next_allowin_i      (next_allowin_i),
        .now_to_next_valid_o (now_to_next_valid_o),
        .id_pc_o             (id_pc_o),
        .id_inst_o           (id_inst_o),
        .id_excep_en_o       (id_excep_en_o),
        .id_excep_type_o     (id_excep_type_o),
        .order_we_o          (order_we_o),
        .order_pc_o          (order_pc_o)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        preif_valid_i       = 1'b0;
        preif_req_i         = 1'b0;
        preif_pc_i          = 32'h0;
        preif_excep_en_i    = 1'b0;
        preif_excep_type_i  = 16'h0;
        flush_i             = 1'b0;
        inst_sram_data_ok_i = 1'b0;
        inst_sram_rdata_i   = 32'h0;
        next_allowin_i      = 1'b1;
    endtask

    task automatic present(input logic [31:0] pc, input logic req);
        preif_valid_i    = 1'b1;
        preif_req_i      = req;
        preif_pc_i       = pc;
        preif_excep_en_i = 1'b0;
        preif_excep_type_i = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        preif_valid_i = 1'b1;
        preif_req_i   = 1'b1;
        preif_pc_i    = 32'h1234_5678;
        inst_sram_rdata_i = 32'haaaa_5555;
        cyc(); cyc();
        #1;
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0h exp=1", now_allowin_o); end
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", now_to_next_valid_o); end
        checks++; if (id_inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=00000000", id_inst_o); end
        checks++; if (id_pc_o !== 32'h0 || order_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", id_pc_o, order_pc_o); end
        checks++; if (order_we_o !== 1'b0 || id_excep_en_o !== 1'b0 || id_excep_type_o !== 16'h0) begin failures++; $display("FAIL reset_misc got=%0h/%0h/%h exp=0/0/0", order_we_o, id_excep_en_o, id_excep_type_o); end
        idle_inputs();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        present(32'h1c00_0000, 1'b1);
        #1;
        checks++; if (now_allowin_o !== 1'b1) begin failures++; $display("FAIL basic_allowin got=%0h exp=1", now_allowin_o); end
        cyc();
        idle_inputs();
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'h0280_0000;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0h exp=1", now_to_next_valid_o); end
        checks++; if (id_inst_o !== 32'h0280_0000) begin failures++; $display("FAIL basic_inst got=%h exp=02800000", id_inst_o); end
        checks++; if (id_pc_o !== 32'h1c00_0000) begin failures++; $display("FAIL basic_pc got=%h exp=1c000000", id_pc_o); end
        checks++; if (order_we_o !== 1'b1 || order_pc_o !== 32'h1c00_0000) begin failures++; $display("FAIL basic_order got=%0h/%h exp=1/1c000000", order_we_o, order_pc_o); end
        cyc();
        idle_inputs();
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0 || now_allowin_o !== 1'b1) begin failures++; $display("FAIL basic_drain got=%0h/%0h exp=0/1", now_to_next_valid_o, now_allowin_o); end
        checks++; if (order_we_o !== 1'b0) begin failures++; $display("FAIL basic_order_clr got=%0h exp=0", order_we_o); end
    endtask

    task automatic test_stall();
        present(32'h1c00_0000, 1'b1);
        cyc();
        idle_inputs();
        next_allowin_i      = 1'b0;
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'h0280_0000;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || now_allowin_o !== 1'b0) begin failures++; $display("FAIL stall_first got=%0h/%0h exp=1/0", now_to_next_valid_o, now_allowin_o); end
        cyc();
        inst_sram_data_ok_i = 1'b0;
        inst_sram_rdata_i   = 32'hffff_ffff;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (id_inst_o !== 32'h0280_0000) begin failures++; $display("FAIL stall_hold_inst[%0d] got=%h exp=02800000", k, id_inst_o); end
            checks++; if (now_to_next_valid_o !== 1'b1 || now_allowin_o !== 1'b0) begin failures++; $display("FAIL stall_hold_hs[%0d] got=%0h/%0h exp=1/0", k, now_to_next_valid_o, now_allowin_o); end
            cyc();
        end
        next_allowin_i = 1'b1;
        #1;
        checks++; if (now_allowin_o !== 1'b1 || id_inst_o !== 32'h0280_0000) begin failures++; $display("FAIL stall_release got=%0h/%h exp=1/02800000", now_allowin_o, id_inst_o); end
        cyc();
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL stall_drain got=%0h exp=0", now_to_next_valid_o); end
        idle_inputs();
    endtask

    task automatic test_flush_discard();
        present(32'h1c00_4000, 1'b1);
        cyc();
        idle_inputs();
        flush_i = 1'b1;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL flush_kill got=%0h exp=0", now_to_next_valid_o); end
        cyc();
        idle_inputs();
        present(32'h1c00_8000, 1'b1);
        cyc();
        idle_inputs();
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'hdead_beef;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL flush_stale_dropped got=%0h exp=0", now_to_next_valid_o); end
        cyc();
        inst_sram_rdata_i = 32'h0010_0000;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || id_inst_o !== 32'h0010_0000) begin failures++; $display("FAIL flush_new_inst got=%0h/%h exp=1/00100000", now_to_next_valid_o, id_inst_o); end
        checks++; if (id_pc_o !== 32'h1c00_8000) begin failures++; $display("FAIL flush_new_pc got=%h exp=1c008000", id_pc_o); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_double_flush();
        present(32'h1c00_0100, 1'b1);
        cyc();
        present(32'h1c00_0104, 1'b1);
        flush_i = 1'b1;
        cyc();
        idle_inputs();
        present(32'h1c00_2000, 1'b1);
        cyc();
        idle_inputs();
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'h1111_1111;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL dbl_drop1 got=%0h exp=0", now_to_next_valid_o); end
        cyc();
        inst_sram_rdata_i = 32'h2222_2222;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL dbl_drop2 got=%0h exp=0", now_to_next_valid_o); end
        cyc();
        inst_sram_rdata_i = 32'h3333_3333;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || id_inst_o !== 32'h3333_3333) begin failures++; $display("FAIL dbl_third got=%0h/%h exp=1/33333333", now_to_next_valid_o, id_inst_o); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_exception();
        preif_valid_i      = 1'b1;
        preif_req_i        = 1'b0;
        preif_pc_i         = 32'h1c00_abcc;
        preif_excep_en_i   = 1'b1;
        preif_excep_type_i = 16'h0001;
        cyc();
        idle_inputs();
        inst_sram_rdata_i = 32'hcafe_f00d;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1) begin failures++; $display("FAIL exc_valid got=%0h exp=1", now_to_next_valid_o); end
        checks++; if (id_inst_o !== 32'h0) begin failures++; $display("FAIL exc_inst got=%h exp=00000000", id_inst_o); end
        checks++; if (id_excep_en_o !== 1'b1 || id_excep_type_o !== 16'h0001) begin failures++; $display("FAIL exc_vector got=%0h/%h exp=1/0001", id_excep_en_o, id_excep_type_o); end
        checks++; if (order_we_o !== 1'b0 || id_pc_o !== 32'h1c00_abcc) begin failures++; $display("FAIL exc_pc_order got=%0h/%h exp=0/1c00abcc", order_we_o, id_pc_o); end
        cyc();
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL exc_drain got=%0h exp=0", now_to_next_valid_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        present(32'h1c00_0200, 1'b1);
        cyc();
        idle_inputs();
        flush_i = 1'b1;
        cyc();
        idle_inputs();
        present(32'h1c00_0300, 1'b1);
        cyc();
        idle_inputs();
        rst = 1'b1;
        inst_sram_rdata_i = 32'h1234_5678;
        cyc();
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0 || now_allowin_o !== 1'b1) begin failures++; $display("FAIL rstmid_hs got=%0h/%0h exp=0/1", now_to_next_valid_o, now_allowin_o); end
        checks++; if (id_inst_o !== 32'h0 || id_pc_o !== 32'h0 || order_pc_o !== 32'h0 || order_we_o !== 1'b0) begin failures++; $display("FAIL rstmid_out got=%h/%h/%h/%0h exp=0/0/0/0", id_inst_o, id_pc_o, order_pc_o, order_we_o); end
        rst = 1'b0;
        idle_inputs();
        present(32'h1c00_0400, 1'b1);
        cyc();
        idle_inputs();
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'h0bad_c0de;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || id_inst_o !== 32'h0bad_c0de) begin failures++; $display("FAIL rstmid_counter_cleared got=%0h/%h exp=1/0badc0de", now_to_next_valid_o, id_inst_o); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        present(32'h1c00_1000, 1'b1);
        cyc();
        present(32'h1c00_1004, 1'b1);
        inst_sram_data_ok_i = 1'b1;
        inst_sram_rdata_i   = 32'h0000_00a1;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || id_inst_o !== 32'h0000_00a1 || now_allowin_o !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0h/%h/%0h exp=1/000000a1/1", now_to_next_valid_o, id_inst_o, now_allowin_o); end
        cyc();
        preif_valid_i     = 1'b0;
        inst_sram_rdata_i = 32'h0000_00b2;
        #1;
        checks++; if (now_to_next_valid_o !== 1'b1 || id_inst_o !== 32'h0000_00b2) begin failures++; $display("FAIL b2b_second got=%0h/%h exp=1/000000b2", now_to_next_valid_o, id_inst_o); end
        checks++; if (id_pc_o !== 32'h1c00_1004 || order_pc_o !== 32'h1c00_1004 || order_we_o !== 1'b1) begin failures++; $display("FAIL b2b_pc got=%h/%h/%0h exp=1c001004/1c001004/1", id_pc_o, order_pc_o, order_we_o); end
        cyc();
        idle_inputs();
        #1;
        checks++; if (now_to_next_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", now_to_next_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_discard();
        test_double_flush();
        test_exception();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch (IF) pipeline stage of the LoongArch 7-stage core. It sits between PreIF and ID. It accepts one fetch entry per handshake from PreIF: the PC, the request-issued flag and any fetch-exception tag. It waits for the instruction SRAM `data_ok` response and buffers the instruction while ID stalls. After a pipeline flush it discards stale responses. It also feeds the sequential-PC hint back to PreIF.

## Interface
Parameters:
- `PC_W`, 32, PC / instruction address width
- `INST_W`, 32, instruction word width
- `EXC_W`, 16, exception-type vector width (same encoding as the pipeline exception bus)

Ports:
- `clk`  in  1  core clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `preif_valid_i`  in  1  PreIF entry valid (PreIF ready_go)
- `preif_req_i`  in  1  PreIF issued an inst SRAM request for this entry (addr_ok already received)
- `preif_pc_i`  in  PC_W  entry PC
- `preif_excep_en_i`  in  1  fetch-side exception (e.g. interrupt tag)
- `preif_excep_type_i`  in  EXC_W  exception type vector
- `now_allowin_o`  out  1  IF can accept an entry this cycle
- `flush_i`  in  1  exception/ertn/branch flush; kills the IF entry
- `inst_sram_data_ok_i`  in  1  read data returned
- `inst_sram_rdata_i`  in  INST_W  read data
- `next_allowin_i`  in  1  ID can accept
- `now_to_next_valid_o`  out  1  IF entry ready for ID
- `id_pc_o`  out  PC_W  entry PC to ID
- `id_inst_o`  out  INST_W  instruction to ID (0 when no request was issued)
- `id_excep_en_o`  out  1  exception flag to ID
- `id_excep_type_o`  out  EXC_W  exception vector to ID
- `order_we_o`  out  1  sequential-PC hint valid to PreIF
- `order_pc_o`  out  PC_W  PC of current IF entry (PreIF fetches `order_pc_o`+4)

## Operation
Stage registers:
- `valid_q`, `req_q`, `pc_q`, `exc_en_q`, `exc_type_q`
- `ibuf_q` (INST_W) and `ibuf_vld_q`
- `discard_q` (2-bit counter)
- `order_q`

Ready and handshake:
- `ready_go = valid_q && (!req_q || exc_en_q || ibuf_vld_q || (inst_sram_data_ok_i && discard_q==0))`
- `now_allowin_o = !valid_q || (ready_go && next_allowin_i)`
- `now_to_next_valid_o = valid_q && ready_go && !flush_i`
- Accept when `preif_valid_i && now_allowin_o && !flush_i`: load entry, clear `ibuf_vld_q`. Otherwise, if the entry leaves to ID, `valid_q` <= 0.

Response handling:
- A `data_ok` with `discard_q`>0 is dropped and decrements `discard_q`. It never reaches `ibuf_q` or ID.
- A `data_ok` with `discard_q`==0 while `valid_q && req_q && !ibuf_vld_q`: the data bypasses to `id_inst_o`. If ID does not take the entry that cycle, the data is captured into `ibuf_q` and `ibuf_vld_q` <= 1.

Output selection:
- `id_inst_o = ibuf_vld_q ? ibuf_q : (req_q ? inst_sram_rdata_i : 0)`
- When `req_q`=0 (exception entry, no request), IF forwards an inert non-empty entry carrying `exc_en_q`/`exc_type_q`.

Flush:
- `valid_q` <= 0 and `ibuf_vld_q` <= 0.
- `discard_q` increments by one for each outstanding request that is killed:
  - (a) the current entry, when `valid_q && req_q && !ibuf_vld_q && !(data_ok && discard_q==0)`;
  - (b) the PreIF entry presented this cycle, when `preif_valid_i && preif_req_i`.
- The increment is net of a simultaneous discard decrement. `discard_q` saturates at 3; reaching the limit is a design error that an assertion flags.

Feedback to PreIF:
- `order_q` <= 1 in the cycle after an accept with `preif_req_i`=1. Cleared on flush, on reset and when the entry leaves.
- `order_we_o = order_q && valid_q`; `order_pc_o = pc_q`.

## Timing
- Reset: all state 0; all outputs 0 (`now_allowin_o`=1, because `valid_q`=0).
- Minimum latency PreIF accept to ID valid is 1 cycle, when `data_ok` arrives in the first cycle after accept.
- Entries are held indefinitely while `next_allowin_i`=0; outputs stay stable.
- Flush has priority over accept and over ID handoff in the same cycle.
- Reset mid-transaction clears `discard_q`. The memory interface is reset concurrently.
- All outputs are combinational from registers plus `data_ok`/`rdata`/`flush_i`/`next_allowin_i`. There is no path from `preif_*` to any output.

## Structure
- The shared header `DefineModuleBus.h` holds the PreIF→IF and IF→ID bus width macros, `EXC_W`, and the exception-type bit locations.
- One natural sub-module: `if_discard_cnt`, the 2-bit saturating counter with inc0/inc1/dec inputs.

## Test plan
- Accept PC 0x1c000000 with req=1; `data_ok` one cycle later with rdata 0x02800000; ID allowin=1 → ID valid that cycle, `id_inst_o`=0x02800000, `order_pc_o`=0x1c000000.
- Same, but ID allowin=0 for 3 cycles → data buffered; `id_inst_o` stays 0x02800000; `now_allowin_o`=0 until handoff.
- Flush while req outstanding, next `data_ok` rdata 0xdeadbeef, then new entry PC 0x1c008000 with rdata 0x00100000 → 0xdeadbeef dropped, ID sees 0x00100000.
- Flush with an outstanding IF request and a PreIF req entry in the same cycle → `discard_q`=2; the next two `data_ok` are dropped.
- Entry with excep_en=1, req=0, INT bit set → ID valid next cycle, inst=0, exception vector intact, no `data_ok` awaited.
- Assert `rst` mid-transaction with `discard_q`=1 → next cycle all outputs 0, `now_allowin_o`=1, `discard_q`=0.
